// File: rtl/regfile_pkg.sv
// Shared definitions for the register file, its busy scoreboard, and the decode/writeback stages.
package regfile_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned NREG_DEF   = 32;
  localparam int unsigned AW_DEF     = $clog2(NREG_DEF);
  localparam int unsigned ZERO_REG   = 0;
  localparam int unsigned A0_IDX_DEF = 10;

  // Architectural register index, used by decode and writeback.
  typedef logic [AW_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_scoreboard_busy_table.sv
// Per-register busy bits.
// A set (issue) takes priority over a clear (writeback), flush overrides both,
// and register zero is never busy. The ebusy lookups hide a busy bit that is
// being cleared in the same cycle.
module busy_table
  import regfile_pkg::*;
#(
  parameter  int unsigned NREG = NREG_DEF,
  localparam int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_idx_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_idx_i,
  input  logic          flush_i,
  input  logic [AW-1:0] look1_idx_i,
  input  logic [AW-1:0] look2_idx_i,
  input  logic [AW-1:0] look3_idx_i,
  output logic          ebusy1_c_o,
  output logic          ebusy2_c_o,
  output logic          ebusy3_c_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Effective busy: a same-cycle writeback resolves the hazard.
  assign ebusy1_c_o = busy_q[look1_idx_i] & ~(clr_en_i & (clr_idx_i == look1_idx_i));
  assign ebusy2_c_o = busy_q[look2_idx_i] & ~(clr_en_i & (clr_idx_i == look2_idx_i));
  assign ebusy3_c_o = busy_q[look3_idx_i] & ~(clr_en_i & (clr_idx_i == look3_idx_i));

  // Next busy vector: clear, then set (set wins), then flush (overrides all).
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
    if (set_en_i) busy_d[set_idx_i] = 1'b1;
    if (flush_i)  busy_d = '0;
    busy_d[AW'(ZERO_REG)] = 1'b0;
  end

  // Busy register; reset discards all pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// NREG x XLEN register file with two combinational read ports, a
// write-through bypassed write port, a hard-wired zero register, and a busy
// scoreboard that stalls decode on RAW/WAW hazards. reg[A0_IDX] is mirrored
// on a0.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int unsigned XLEN   = XLEN_DEF,
  parameter  int unsigned NREG   = NREG_DEF,
  parameter  int unsigned A0_IDX = A0_IDX_DEF,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rd1_addr,
  input  logic [AW-1:0]   rd2_addr,
  output logic [XLEN-1:0] rd1_data,
  output logic [XLEN-1:0] rd2_data,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_use1,
  input  logic            issue_use2,
  input  logic            flush,
  output logic            stall,
  output logic [XLEN-1:0] a0
);

  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);
  localparam logic [AW-1:0] A0_A   = AW'(A0_IDX);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [XLEN-1:0] a0_q;
  logic [XLEN-1:0] a0_d;

  logic wr_we_c;
  logic set_en_c;
  logic ebusy1_c;
  logic ebusy2_c;
  logic ebusy3_c;

  // Writes to register zero are discarded.
  assign wr_we_c = wr_en & (wr_addr != ZERO_A);

  // Read ports: zero register, then write-through bypass, then array.
  always_comb begin
    rd1_data = regs_q[rd1_addr];
    rd2_data = regs_q[rd2_addr];
    if (wr_en && (wr_addr == rd1_addr)) rd1_data = wr_data;
    if (wr_en && (wr_addr == rd2_addr)) rd2_data = wr_data;
    if (rd1_addr == ZERO_A) rd1_data = '0;
    if (rd2_addr == ZERO_A) rd2_data = '0;
  end

  // Hazard stall: RAW on used sources, WAW on destination; flush suppresses it.
  assign stall = issue_valid & ~flush &
                 ((issue_use1 & ebusy1_c) | (issue_use2 & ebusy2_c) | ebusy3_c);

  // A successful issue with a real destination marks it busy.
  assign set_en_c = issue_valid & ~stall & ~flush & (issue_rd != ZERO_A);

  busy_table #(
    .NREG (NREG)
  ) u_busy (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_en_i    (set_en_c),
    .set_idx_i   (issue_rd),
    .clr_en_i    (wr_we_c),
    .clr_idx_i   (wr_addr),
    .flush_i     (flush),
    .look1_idx_i (rd1_addr),
    .look2_idx_i (rd2_addr),
    .look3_idx_i (issue_rd),
    .ebusy1_c_o  (ebusy1_c),
    .ebusy2_c_o  (ebusy2_c),
    .ebusy3_c_o  (ebusy3_c)
  );

  // Next array contents and the a0 mirror of the post-write value.
  always_comb begin
    regs_d = regs_q;
    if (wr_we_c) regs_d[wr_addr] = wr_data;
    a0_d = regs_d[A0_A];
  end

  // Array and a0 registers; reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
      a0_q <= '0;
    end else begin
      regs_q <= regs_d;
      a0_q   <= a0_d;
    end
  end

  assign a0 = a0_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expected values are queued when the
// stimulus is driven and popped when the corresponding output is sampled.
module tb_regfile_scoreboard;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = 5;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   rd1_addr, rd2_addr, wr_addr, issue_rd;
  logic [XLEN-1:0] rd1_data, rd2_data, wr_data, a0;
  logic            wr_en, issue_valid, issue_use1, issue_use2, flush, stall;

  typedef struct {
    string           tag;
    logic [XLEN-1:0] exp;
  } exp_t;

  exp_t sb_q [$];
  int   checks   = 0;
  int   failures = 0;

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .A0_IDX(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd1_addr    (rd1_addr),
    .rd2_addr    (rd2_addr),
    .rd1_data    (rd1_data),
    .rd2_data    (rd2_data),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_use1  (issue_use1),
    .issue_use2  (issue_use2),
    .flush       (flush),
    .stall       (stall),
    .a0          (a0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [XLEN-1:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check(input logic [XLEN-1:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  // Advance to 2 time units after the next rising edge, where inputs change.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_use1 = 1'b0; issue_use2 = 1'b0;
    flush = 1'b0; rd1_addr = '0; rd2_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Reset state: all reads zero, no stall, a0 zero.
    next_cycle();
    for (int i = 0; i < int'(NREG); i++) begin
      rd1_addr = AW'(i);
      rd2_addr = AW'(NREG - 1 - i);
      push($sformatf("reset_rd1_x%0d", i), '0);
      push($sformatf("reset_rd2_x%0d", NREG - 1 - i), '0);
      #1;
      check(rd1_data);
      check(rd2_data);
    end
    push("reset_stall", '0); check(32'(stall));
    push("reset_a0", '0);    check(a0);

    // Write x5 with same-cycle bypass, then array read; x0 stays zero.
    next_cycle();
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; rd1_addr = 5;
    push("bypass_x5", 32'hDEADBEEF); #1; check(rd1_data);
    next_cycle();
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h1234; rd1_addr = 5; rd2_addr = 0;
    push("array_x5", 32'hDEADBEEF); push("x0_bypass_blocked", '0);
    #1; check(rd1_data); check(rd2_data);
    next_cycle();
    wr_en = 1'b0;
    push("x0_after_write", '0); #1; check(rd2_data);

    // RAW: issue rd=7, dependent stalls until writeback resolves it.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 7;
    push("raw_issue_producer", '0); #1; check(32'(stall));
    next_cycle();
    issue_rd = 0; issue_use1 = 1'b1; rd1_addr = 7;
    push("raw_stall_1", 32'd1); #1; check(32'(stall));
    next_cycle();
    push("raw_stall_2", 32'd1); #1; check(32'(stall));
    next_cycle();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55;
    push("raw_stall_drop", '0); push("raw_bypass_data", 32'h55);
    #1; check(32'(stall)); check(rd1_data);
    next_cycle();
    idle_inputs();

    // WAW: busy x3, re-issue stalls; re-issue in writeback cycle keeps busy.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 3;
    push("waw_first_issue", '0); #1; check(32'(stall));
    next_cycle();
    push("waw_stall", 32'd1); #1; check(32'(stall));
    next_cycle();
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h33;
    push("waw_reissue_on_wb", '0); #1; check(32'(stall));
    next_cycle();
    wr_en = 1'b0; issue_rd = 0; issue_use1 = 1'b1; rd1_addr = 3;
    push("waw_set_wins", 32'd1); #1; check(32'(stall));
    next_cycle();
    issue_valid = 1'b0; issue_use1 = 1'b0;
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h34;
    next_cycle();
    idle_inputs();

    // Flush: busy x4, x9; flush with issue rd=4 clears all and records nothing.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 4;
    push("flush_issue_x4", '0); #1; check(32'(stall));
    next_cycle();
    issue_rd = 9;
    push("flush_issue_x9", '0); #1; check(32'(stall));
    next_cycle();
    flush = 1'b1; issue_rd = 4; issue_use1 = 1'b1; rd1_addr = 9;
    push("flush_no_stall", '0); #1; check(32'(stall));
    next_cycle();
    flush = 1'b0; issue_rd = 0; issue_use1 = 1'b1; rd1_addr = 4;
    issue_use2 = 1'b1; rd2_addr = 9;
    push("post_flush_clear", '0); #1; check(32'(stall));
    next_cycle();
    issue_use1 = 1'b0; issue_use2 = 1'b0; issue_rd = 4;
    push("post_flush_waw_x4", '0); #1; check(32'(stall));
    next_cycle();
    idle_inputs();
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'h44;

    // a0 mirror lags a write to x10 by one edge.
    next_cycle();
    wr_en = 1'b1; wr_addr = 10; wr_data = 32'hCAFE;
    push("a0_before_edge", '0); #1; check(a0);
    next_cycle();
    wr_en = 1'b0; rd2_addr = 10;
    push("a0_after_edge", 32'hCAFE); push("x10_array", 32'hCAFE);
    #1; check(a0); check(rd2_data);

    // Mid-cycle asynchronous reset with x6 busy.
    next_cycle();
    issue_valid = 1'b1; issue_rd = 6;
    next_cycle();
    issue_rd = 0; issue_use1 = 1'b1; rd1_addr = 6;
    push("pre_reset_stall", 32'd1); #1; check(32'(stall));
    rst_n = 1'b0;
    push("async_reset_a0", '0); push("async_reset_stall", '0); push("async_reset_x10", '0);
    #1; check(a0); check(32'(stall)); check(rd2_data);
    issue_valid = 1'b0; issue_use1 = 1'b0;
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hBAD0BAD0;
    next_cycle();
    wr_en = 1'b0; rd1_addr = 5;
    rst_n = 1'b1;
    push("no_write_in_reset", '0); #1; check(rd1_data);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
